branch_target_lut: RTL
======================

BRANCH_TARGET_LUT -- requirements
Module: branch_target_lut

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, which is the width of each branch target address.
REQ-002 The module SHALL have parameter PTR_W, default 3, which sets entries per program to 2**PTR_W.
REQ-003 The module SHALL have parameter NUM_PROG, default 3, which is the number of program banks; PROG_W = max(1, clog2(NUM_PROG)) is derived from it.
REQ-004 The module SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port Reset, input, 1 bit: a synchronous, active-low reset.
REQ-006 The module SHALL have port busy, output, 1 bit: high while the init sweep runs.
REQ-007 The module SHALL have port wr_en, input, 1 bit: table write strobe.
REQ-008 The module SHALL have ports wr_prog (input, PROG_W), wr_ptr (input, PTR_W) and wr_data (input, ADDR_W): the write bank, entry and target.
REQ-009 The module SHALL have port rd_req, input, 1 bit: lookup request.
REQ-010 The module SHALL have ports prog_sel (input, PROG_W) and rd_ptr (input, PTR_W): the lookup bank and entry.
REQ-011 The module SHALL have ports rd_pc (input, ADDR_W) and rd_rel (input, 1): the current PC and the relative-mode select.
REQ-012 The module SHALL have ports rd_valid (output, 1), rd_addr (output, ADDR_W) and rd_miss (output, 1): the registered lookup result.

Function
REQ-013 The module SHALL have states INIT and RUN.
REQ-014 In INIT, the module SHALL clear one data entry per cycle in bank-major order, covering NUM_PROG*2**PTR_W entries (24 cycles at defaults), and SHALL hold busy=1.
REQ-015 After the last entry is cleared, the module SHALL move from INIT to RUN, and busy SHALL be 0 from the following cycle.
REQ-016 In INIT, rd_req and wr_en SHALL be ignored (no write, rd_valid=0).
REQ-017 In RUN, wr_en=1 with wr_prog<NUM_PROG SHALL store wr_data at [wr_prog][wr_ptr] and set that entry's written bit; if wr_prog>=NUM_PROG, the write SHALL be dropped.
REQ-018 In RUN, rd_req=1 SHALL give rd_valid=1 exactly one cycle later, with rd_addr/rd_miss for that request; rd_valid SHALL be 0 in any cycle following no request.
REQ-019 The lookup result SHALL be rd_miss=0 with rd_addr = stored entry when the entry has its written bit set; an unwritten entry or prog_sel>=NUM_PROG SHALL give rd_miss=1 and rd_addr=0.
REQ-020 A read and a write to the same entry in the same cycle SHALL bypass: the read returns wr_data with rd_miss=0.
REQ-021 rd_addr and rd_miss SHALL hold their last values while rd_valid=0.
REQ-022 Back-to-back requests SHALL be supported, one result per cycle, with no stalls.

Reset
REQ-023 Reset=0 at a clock edge SHALL enter INIT, restart the sweep at entry 0, clear all written bits, and set busy=1, rd_valid=0, rd_addr=0 and rd_miss=0.
REQ-024 Reset asserted mid-sweep or mid-lookup SHALL abort that activity, and no result for the aborted request SHALL be produced.

Configuration
REQ-025 With LUT_RELATIVE_EN defined, a hit with rd_rel=1 SHALL return rd_addr = (rd_pc + entry) mod 2**ADDR_W.
REQ-026 With LUT_RELATIVE_EN defined, a miss SHALL still return 0.
REQ-027 With LUT_RELATIVE_EN undefined, rd_rel and rd_pc SHALL be ignored and absolute targets SHALL always be returned.

Verification
REQ-028 The bench SHALL cover: release Reset at cycle 0 -> busy=1 for exactly 24 cycles, then 0; rd_req during busy -> no rd_valid.
REQ-029 The bench SHALL cover: write prog 1, ptr 5, data 10'h2A4, then read the same entry -> next cycle rd_valid=1, rd_addr=10'h2A4, rd_miss=0.
REQ-030 The bench SHALL cover: read prog 2, ptr 0, never written -> rd_miss=1, rd_addr=0; read with prog_sel=3 -> rd_miss=1.
REQ-031 The bench SHALL cover: same-cycle write of 10'h155 and read of prog 0, ptr 7 -> rd_addr=10'h155, rd_miss=0.
REQ-032 The bench SHALL cover, with LUT_RELATIVE_EN defined: entry 10'h010, rd_pc=10'h3F8, rd_rel=1 -> rd_addr=10'h008 (wrap).
REQ-033 The bench SHALL cover: Reset pulsed after data has been written -> 24-cycle sweep, then a read of the previously written entry -> rd_miss=1.

Source files
------------

// File: rtl/branch_target_lut.sv
// Per-program branch target table: INIT sweep clears every entry, then RUN serves registered lookups with write bypass.
// Optional macro LUT_RELATIVE_EN adds PC-relative targets on hits when rd_rel is set.
module branch_target_lut #(
  parameter int ADDR_W   = 10,
  parameter int PTR_W    = 3,
  parameter int NUM_PROG = 3,
  parameter int PROG_W   = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              busy,
  input  logic              wr_en,
  input  logic [PROG_W-1:0] wr_prog,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [PROG_W-1:0] prog_sel,
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic [ADDR_W-1:0] rd_pc,
  input  logic              rd_rel,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_miss
);

  localparam int DEPTH   = 2**PTR_W;
  localparam int ENTRIES = NUM_PROG * DEPTH;
  localparam int IDX_W   = PROG_W + PTR_W;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(ENTRIES - 1);
  localparam logic [PROG_W:0]   NUM_PROG_V = (PROG_W + 1)'(NUM_PROG);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    sweep_idx;
  logic [ADDR_W-1:0]   mem [ENTRIES];
  logic [ENTRIES-1:0]  written;

  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic                wr_prog_ok, rd_prog_ok;
  logic                wr_fire, rd_fire;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [ADDR_W-1:0]   mem_wdata;
  logic                hit;
  logic [ADDR_W-1:0]   entry;
  logic [ADDR_W-1:0]   lookup_addr;

  // Power-of-two bank depth makes {prog, ptr} the bank-major flat index.
  assign wr_idx     = {wr_prog, wr_ptr};
  assign rd_idx     = {prog_sel, rd_ptr};
  assign wr_prog_ok = {1'b0, wr_prog} < NUM_PROG_V;
  assign rd_prog_ok = {1'b0, prog_sel} < NUM_PROG_V;
  assign wr_fire    = (state_q == RUN) && wr_en && wr_prog_ok;
  assign rd_fire    = (state_q == RUN) && rd_req;
  assign busy       = (state_q == INIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (sweep_idx == LAST_IDX) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdata = wr_data;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_idx;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // A same-cycle write to the looked-up entry wins over the stored copy.
  always_comb begin
    hit   = 1'b0;
    entry = mem[rd_idx];
    if (rd_prog_ok) begin
      if (wr_fire && (wr_idx == rd_idx)) begin
        hit   = 1'b1;
        entry = wr_data;
      end else if (written[rd_idx]) begin
        hit = 1'b1;
      end
    end
    lookup_addr = hit ? entry : '0;
`ifdef LUT_RELATIVE_EN
    if (hit && rd_rel) lookup_addr = rd_pc + entry;
`endif
  end

`ifndef LUT_RELATIVE_EN
  logic unused_rel;
  assign unused_rel = ^{rd_pc, rd_rel};
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= INIT;
      sweep_idx <= '0;
      written   <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      rd_miss   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) sweep_idx <= sweep_idx + IDX_W'(1);
      if (wr_fire) written[wr_idx] <= 1'b1;
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_addr <= lookup_addr;
        rd_miss <= !hit;
      end
    end
  end

endmodule
